// File: rtl/next_pc_unit.sv
// Program-counter / branch-resolution stage with start/run/halt sequencing and a
// programmable branch-target table. Define NPC_REL_BRANCH_EN for pc-relative targets.
module next_pc_unit #(
    parameter int PC_W   = 10,
    parameter int TBL_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PC_W-1:0]   start_addr,
    input  logic              stall_i,
    input  logic              branch_en,
    input  logic [TBL_AW-1:0] branch_idx,
    input  logic [7:0]        alu_rslt,
    input  logic              halt_i,
    input  logic              tbl_we,
    input  logic [TBL_AW-1:0] tbl_waddr,
    input  logic [PC_W-1:0]   tbl_wdata,
    output logic [PC_W-1:0]   pc,
    output logic              running,
    output logic              done,
    output logic              br_taken
);

    localparam int TBL_D = 1 << TBL_AW;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic              r_running;
    logic              r_done;
    logic              r_br_taken;
    logic              w_done_nxt;
    logic              w_br_nxt;
    logic [PC_W-1:0]   r_tbl [TBL_D];
    logic [PC_W-1:0]   w_entry;
    logic [PC_W-1:0]   w_target;
    logic              w_taken;
    logic              w_alu_unused;

    // Table read is taken from the registered array, so a same-cycle write is not yet visible.
    assign w_entry      = r_tbl[branch_idx];
    assign w_taken      = branch_en & alu_rslt[0];
    assign w_alu_unused = ^alu_rslt[7:1];

`ifdef NPC_REL_BRANCH_EN
    // Equal-width modular add is identical to adding the sign-extended entry and truncating.
    assign w_target = r_pc + w_entry;
`else
    assign w_target = w_entry;
`endif

    // Next-state, next-pc and pulse generation with stall > halt > branch > sequential priority.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_done_nxt  = 1'b0;
        w_br_nxt    = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    w_pc_nxt    = start_addr;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_pc_nxt    = r_pc;
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
                if (stall_i) begin
                    w_pc_nxt = r_pc;
                end else if (halt_i) begin
                    w_state_nxt = ST_HALTED;
                    w_done_nxt  = 1'b1;
                end else if (w_taken) begin
                    w_pc_nxt = w_target;
                    w_br_nxt = 1'b1;
                end else begin
                    w_pc_nxt = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = r_pc;
            end
        endcase
    end

    // Sequencer state, pc and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= {PC_W{1'b0}};
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_br_taken <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_running  <= (w_state_nxt == ST_RUN);
            r_done     <= w_done_nxt;
            r_br_taken <= w_br_nxt;
        end
    end

    // Branch-target table; writable in every state, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TBL_D; i++) begin
                r_tbl[i] <= {PC_W{1'b0}};
            end
        end else if (tbl_we) begin
            r_tbl[tbl_waddr] <= tbl_wdata;
        end else begin
            r_tbl[tbl_waddr] <= r_tbl[tbl_waddr];
        end
    end

    assign pc       = r_pc;
    assign running  = r_running;
    assign done     = r_done;
    assign br_taken = r_br_taken;

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit: stimulus queues hand-computed expectations,
// an independent monitor compares them against the DUT after each rising edge.
module tb_next_pc_unit;

    logic       clk;
    logic       reset;
    logic       start;
    logic [9:0] start_addr;
    logic       stall_i;
    logic       branch_en;
    logic [3:0] branch_idx;
    logic [7:0] alu_rslt;
    logic       halt_i;
    logic       tbl_we;
    logic [3:0] tbl_waddr;
    logic [9:0] tbl_wdata;
    logic [9:0] pc;
    logic       running;
    logic       done;
    logic       br_taken;

    typedef struct {
        string      name;
        logic [9:0] pc;
        logic       run;
        logic       done;
        logic       br;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    next_pc_unit #(.PC_W(10), .TBL_AW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .stall_i    (stall_i),
        .branch_en  (branch_en),
        .branch_idx (branch_idx),
        .alu_rslt   (alu_rslt),
        .halt_i     (halt_i),
        .tbl_we     (tbl_we),
        .tbl_waddr  (tbl_waddr),
        .tbl_wdata  (tbl_wdata),
        .pc         (pc),
        .running    (running),
        .done       (done),
        .br_taken   (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] exp_tgt(input logic [9:0] cur_pc, input logic [9:0] entry);
`ifdef NPC_REL_BRANCH_EN
        return cur_pc + entry;
`else
        return entry;
`endif
    endfunction

    task automatic clear_inputs();
        reset      = 1'b0;
        start      = 1'b0;
        start_addr = 10'h000;
        stall_i    = 1'b0;
        branch_en  = 1'b0;
        branch_idx = 4'h0;
        alu_rslt   = 8'h00;
        halt_i     = 1'b0;
        tbl_we     = 1'b0;
        tbl_waddr  = 4'h0;
        tbl_wdata  = 10'h000;
    endtask

    // Queue the outputs expected after the coming edge, then advance one cycle.
    task automatic step(input string nm, input logic [9:0] epc, input logic erun,
                        input logic edone, input logic ebr);
        exp_t e;
        e.name = nm;
        e.pc   = epc;
        e.run  = erun;
        e.done = edone;
        e.br   = ebr;
        sb.push_back(e);
        @(negedge clk);
        clear_inputs();
    endtask

    // Monitor: one expectation is consumed per rising edge while any are pending.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if ({pc, running, done, br_taken} !== {e.pc, e.run, e.done, e.br}) begin
                n_err++;
                $display("FAIL %s: got pc=%h running=%b done=%b br_taken=%b, expected pc=%h running=%b done=%b br_taken=%b",
                         e.name, pc, running, done, br_taken, e.pc, e.run, e.done, e.br);
            end
        end
    end

    initial begin
        logic [9:0] p;
        logic [9:0] p2;
        logic [9:0] p3;
        clear_inputs();

        reset = 1'b1;
        step("rst0", 10'h000, 1'b0, 1'b0, 1'b0);
        reset = 1'b1; start = 1'b1; start_addr = 10'h155;
        step("rst1_start_ignored", 10'h000, 1'b0, 1'b0, 1'b0);

        start = 1'b1; start_addr = 10'h010;
        step("start_010", 10'h010, 1'b1, 1'b0, 1'b0);
        step("seq_011", 10'h011, 1'b1, 1'b0, 1'b0);
        tbl_we = 1'b1; tbl_waddr = 4'd3; tbl_wdata = 10'h200;
        step("seq_012_wr3", 10'h012, 1'b1, 1'b0, 1'b0);
        tbl_we = 1'b1; tbl_waddr = 4'd5; tbl_wdata = 10'h050;
        step("seq_013_wr5", 10'h013, 1'b1, 1'b0, 1'b0);

        halt_i = 1'b1;
        step("halt_a", 10'h013, 1'b0, 1'b1, 1'b0);
        step("halted_a", 10'h013, 1'b0, 1'b0, 1'b0);
        start = 1'b1; start_addr = 10'h020;
        step("restart_020", 10'h020, 1'b1, 1'b0, 1'b0);

        branch_en = 1'b1; branch_idx = 4'd3; alu_rslt = 8'h01;
        p = exp_tgt(10'h020, 10'h200);
        step("br_taken_idx3", p, 1'b1, 1'b0, 1'b1);
        halt_i = 1'b1;
        step("halt_b", p, 1'b0, 1'b1, 1'b0);
        start = 1'b1; start_addr = 10'h020;
        step("restart2_020", 10'h020, 1'b1, 1'b0, 1'b0);
        branch_en = 1'b1; branch_idx = 4'd3; alu_rslt = 8'hFE;
        step("br_not_taken", 10'h021, 1'b1, 1'b0, 1'b0);

        stall_i = 1'b1; halt_i = 1'b1; branch_en = 1'b1; branch_idx = 4'd3; alu_rslt = 8'h01;
        step("prio_stall", 10'h021, 1'b1, 1'b0, 1'b0);
        halt_i = 1'b1; branch_en = 1'b1; branch_idx = 4'd3; alu_rslt = 8'h01;
        step("prio_halt", 10'h021, 1'b0, 1'b1, 1'b0);
        branch_en = 1'b1; branch_idx = 4'd3; alu_rslt = 8'h01;
        step("halted_branch_ignored", 10'h021, 1'b0, 1'b0, 1'b0);

        start = 1'b1; start_addr = 10'h3FE;
        step("start_3fe", 10'h3FE, 1'b1, 1'b0, 1'b0);
        start = 1'b1; start_addr = 10'h155;
        step("seq_3ff_start_ignored", 10'h3FF, 1'b1, 1'b0, 1'b0);
        tbl_we = 1'b1; tbl_waddr = 4'd1; tbl_wdata = 10'h3FE;
        step("wrap_000", 10'h000, 1'b1, 1'b0, 1'b0);
        step("seq_001", 10'h001, 1'b1, 1'b0, 1'b0);
        branch_en = 1'b1; branch_idx = 4'd1; alu_rslt = 8'h03;
        p = exp_tgt(10'h001, 10'h3FE);
        step("br_idx1_minus2", p, 1'b1, 1'b0, 1'b1);

        tbl_we = 1'b1; tbl_waddr = 4'd5; tbl_wdata = 10'h060;
        branch_en = 1'b1; branch_idx = 4'd5; alu_rslt = 8'h01;
        p2 = exp_tgt(p, 10'h050);
        step("hazard_old_value", p2, 1'b1, 1'b0, 1'b1);
        branch_en = 1'b1; branch_idx = 4'd5; alu_rslt = 8'h81;
        p3 = exp_tgt(p2, 10'h060);
        step("hazard_new_value", p3, 1'b1, 1'b0, 1'b1);

        reset = 1'b1; start = 1'b1; start_addr = 10'h155;
        branch_en = 1'b1; branch_idx = 4'd3; alu_rslt = 8'h01;
        step("reset_mid_run", 10'h000, 1'b0, 1'b0, 1'b0);
        start = 1'b1; start_addr = 10'h030;
        step("start_030", 10'h030, 1'b1, 1'b0, 1'b0);
        branch_en = 1'b1; branch_idx = 4'd3; alu_rslt = 8'h01;
        p = exp_tgt(10'h030, 10'h000);
        step("br_table_cleared", p, 1'b1, 1'b0, 1'b1);
        halt_i = 1'b1;
        step("halt_c", p, 1'b0, 1'b1, 1'b0);
        step("halted_c", p, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations still pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
